// File: rtl/execute_stage_pkg.sv
// Shared types for the RV32I execute stage.
package execute_stage_pkg;

  // ALU operation selector; ALU_COMPARE_* return 1 when the branch condition holds.
  typedef enum logic [4:0] {
    ALU_ADD         = 5'd0,
    ALU_SUB         = 5'd1,
    ALU_SLL         = 5'd2,
    ALU_SLT         = 5'd3,
    ALU_SLTU        = 5'd4,
    ALU_XOR         = 5'd5,
    ALU_SRL         = 5'd6,
    ALU_SRA         = 5'd7,
    ALU_OR          = 5'd8,
    ALU_AND         = 5'd9,
    ALU_PASS_B      = 5'd10,
    ALU_COMPARE_EQ  = 5'd11,
    ALU_COMPARE_NE  = 5'd12,
    ALU_COMPARE_LT  = 5'd13,
    ALU_COMPARE_GE  = 5'd14,
    ALU_COMPARE_LTU = 5'd15,
    ALU_COMPARE_GEU = 5'd16
  } alu_op_t;

endpackage

// File: rtl/execute_stage.sv
// RV32I execute stage: operand bypass, ALU, branch/jump resolution and EX/MEM register.
module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,

  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [4:0]      in_rs1_addr,
  input  logic [4:0]      in_rs2_addr,
  input  logic [4:0]      in_rd_addr,
  input  logic [XLEN-1:0] in_rs1_value,
  input  logic [XLEN-1:0] in_rs2_value,
  input  logic [XLEN-1:0] in_imm,
  input  alu_op_t         in_alu_op,
  input  logic            in_op1_pc,
  input  logic            in_op2_imm,
  input  logic            in_is_branch,
  input  logic            in_is_jal,
  input  logic            in_is_jalr,

  input  logic            fwd_mem_valid,
  input  logic [4:0]      fwd_mem_rd,
  input  logic [XLEN-1:0] fwd_mem_value,
  input  logic            fwd_wb_valid,
  input  logic [4:0]      fwd_wb_rd,
  input  logic [XLEN-1:0] fwd_wb_value,

  input  logic            flush,

  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_result,
  output logic [XLEN-1:0] out_store_data,
  output logic [4:0]      out_rd_addr,

  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  localparam int unsigned SHW = $clog2(XLEN);

  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic [XLEN-1:0] alu_y;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] pc_plus_4;
  logic [XLEN-1:0] branch_target;
  logic [XLEN-1:0] jalr_target;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_eff;
  logic            is_jump;
  logic            taken;
  logic            accept;

  // Youngest producer wins: MEM over WB over register file; x0 is hardwired to zero.
  function automatic logic [XLEN-1:0] bypass(
    input logic [4:0]      idx,
    input logic [XLEN-1:0] rf_value,
    input logic            mem_v,
    input logic [4:0]      mem_rd,
    input logic [XLEN-1:0] mem_value,
    input logic            wb_v,
    input logic [4:0]      wb_rd,
    input logic [XLEN-1:0] wb_value
  );
    logic [XLEN-1:0] v;
    v = rf_value;
    if (idx == 5'd0) begin
      v = '0;
    end else if (mem_v && (mem_rd == idx)) begin
      v = mem_value;
    end else if (wb_v && (wb_rd == idx)) begin
      v = wb_value;
    end
    return v;
  endfunction

  // Forwarded source operands and ALU operand muxing.
  always_comb begin
    rs1_fwd = bypass(in_rs1_addr, in_rs1_value, fwd_mem_valid, fwd_mem_rd, fwd_mem_value,
                     fwd_wb_valid, fwd_wb_rd, fwd_wb_value);
    rs2_fwd = bypass(in_rs2_addr, in_rs2_value, fwd_mem_valid, fwd_mem_rd, fwd_mem_value,
                     fwd_wb_valid, fwd_wb_rd, fwd_wb_value);
    op1     = in_op1_pc  ? in_pc  : rs1_fwd;
    op2     = in_op2_imm ? in_imm : rs2_fwd;
  end

  // Combinational ALU.
  always_comb begin
    alu_y = '0;
    shamt = op2[SHW-1:0];
    unique case (in_alu_op)
      ALU_ADD:         alu_y = op1 + op2;
      ALU_SUB:         alu_y = op1 - op2;
      ALU_SLL:         alu_y = op1 << shamt;
      ALU_SLT:         alu_y = XLEN'($signed(op1) < $signed(op2));
      ALU_SLTU:        alu_y = XLEN'(op1 < op2);
      ALU_XOR:         alu_y = op1 ^ op2;
      ALU_SRL:         alu_y = op1 >> shamt;
      ALU_SRA:         alu_y = $unsigned($signed(op1) >>> shamt);
      ALU_OR:          alu_y = op1 | op2;
      ALU_AND:         alu_y = op1 & op2;
      ALU_PASS_B:      alu_y = op2;
      ALU_COMPARE_EQ:  alu_y = XLEN'(op1 == op2);
      ALU_COMPARE_NE:  alu_y = XLEN'(op1 != op2);
      ALU_COMPARE_LT:  alu_y = XLEN'($signed(op1) < $signed(op2));
      ALU_COMPARE_GE:  alu_y = XLEN'(!($signed(op1) < $signed(op2)));
      ALU_COMPARE_LTU: alu_y = XLEN'(op1 < op2);
      ALU_COMPARE_GEU: alu_y = XLEN'(!(op1 < op2));
      default:         alu_y = '0;
    endcase
  end

  // Control-transfer resolution and writeback selection; sums wrap modulo 2^XLEN.
  always_comb begin
    pc_plus_4     = in_pc + XLEN'(4);
    branch_target = in_pc + in_imm;
    jalr_target   = (rs1_fwd + in_imm) & ~XLEN'(1);
    is_jump       = in_is_jal | in_is_jalr;
    target        = in_is_jalr ? jalr_target : branch_target;
    taken         = is_jump | (in_is_branch & (|alu_y));
    result        = is_jump ? pc_plus_4 : alu_y;
    rd_eff        = in_is_branch ? 5'd0 : in_rd_addr;
  end

  // Handshake: single-entry output register; the slot behind a taken transfer is dropped.
  always_comb begin
    in_ready = !out_valid | out_ready;
    accept   = in_valid & in_ready & !flush & !redirect_valid;
  end

  // Output valid and one-shot redirect pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      redirect_valid <= 1'b0;
    end else begin
      redirect_valid <= accept & taken;
      if (accept) begin
        out_valid <= 1'b1;
      end else if (out_ready | flush) begin
        out_valid <= 1'b0;
      end
    end
  end

  // EX/MEM payload and redirect target; held while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_pc         <= '0;
      out_result     <= '0;
      out_store_data <= '0;
      out_rd_addr    <= '0;
      redirect_pc    <= '0;
    end else begin
      if (accept) begin
        out_pc         <= in_pc;
        out_result     <= result;
        out_store_data <= rs2_fwd;
        out_rd_addr    <= rd_eff;
      end
      if (accept & taken) begin
        redirect_pc <= target;
      end
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage with an expected-result queue.
module tb_execute_stage;
  import execute_stage_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [4:0]  in_rs1_addr;
  logic [4:0]  in_rs2_addr;
  logic [4:0]  in_rd_addr;
  logic [31:0] in_rs1_value;
  logic [31:0] in_rs2_value;
  logic [31:0] in_imm;
  alu_op_t     in_alu_op;
  logic        in_op1_pc;
  logic        in_op2_imm;
  logic        in_is_branch;
  logic        in_is_jal;
  logic        in_is_jalr;
  logic        fwd_mem_valid;
  logic [4:0]  fwd_mem_rd;
  logic [31:0] fwd_mem_value;
  logic        fwd_wb_valid;
  logic [4:0]  fwd_wb_rd;
  logic [31:0] fwd_wb_value;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_result;
  logic [31:0] out_store_data;
  logic [4:0]  out_rd_addr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  execute_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
    .in_rs1_value(in_rs1_value), .in_rs2_value(in_rs2_value), .in_imm(in_imm),
    .in_alu_op(in_alu_op), .in_op1_pc(in_op1_pc), .in_op2_imm(in_op2_imm),
    .in_is_branch(in_is_branch), .in_is_jal(in_is_jal), .in_is_jalr(in_is_jalr),
    .fwd_mem_valid(fwd_mem_valid), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_value(fwd_mem_value),
    .fwd_wb_valid(fwd_wb_valid), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_value(fwd_wb_value),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_result(out_result), .out_store_data(out_store_data), .out_rd_addr(out_rd_addr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [31:0] result;
    logic [31:0] store;
    logic [4:0]  rd;
    logic        taken;
    logic [31:0] rpc;
  } exp_t;

  exp_t sb_q[$];
  exp_t last;
  int   vectors;
  int   miscompares;
  logic acc_pending;
  logic model_ov;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    in_valid      = 1'b0;
    fwd_mem_valid = 1'b0;
    fwd_wb_valid  = 1'b0;
    flush         = 1'b0;
  endtask

  // kind: 0 plain, 1 branch, 2 jal, 3 jalr
  task automatic instr(input logic [31:0] pc, input logic [4:0] rs1a, input logic [31:0] rs1v,
                       input logic [4:0] rs2a, input logic [31:0] rs2v, input logic [4:0] rd,
                       input logic [31:0] imm, input alu_op_t op, input logic op1pc,
                       input logic op2imm, input int kind);
    in_valid      = 1'b1;
    in_pc         = pc;
    in_rs1_addr   = rs1a;
    in_rs1_value  = rs1v;
    in_rs2_addr   = rs2a;
    in_rs2_value  = rs2v;
    in_rd_addr    = rd;
    in_imm        = imm;
    in_alu_op     = op;
    in_op1_pc     = op1pc;
    in_op2_imm    = op2imm;
    in_is_branch  = (kind == 1);
    in_is_jal     = (kind == 2);
    in_is_jalr    = (kind == 3);
    fwd_mem_valid = 1'b0;
    fwd_wb_valid  = 1'b0;
    flush         = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] result, input logic [31:0] store,
                            input logic [4:0] rd, input logic taken, input logic [31:0] rpc);
    exp_t e;
    e.tag = tag; e.pc = in_pc; e.result = result; e.store = store;
    e.rd = rd; e.taken = taken; e.rpc = rpc;
    sb_q.push_back(e);
    acc_pending = 1'b1;
  endtask

  task automatic check_outputs(input string tag, input exp_t e, input logic rv);
    check({tag, ".valid"},    32'(out_valid),      32'(1'b1));
    check({tag, ".pc"},       out_pc,              e.pc);
    check({tag, ".result"},   out_result,          e.result);
    check({tag, ".store"},    out_store_data,      e.store);
    check({tag, ".rd"},       32'(out_rd_addr),    32'(e.rd));
    check({tag, ".redirect"}, 32'(redirect_valid), 32'(rv));
    if (rv) check({tag, ".redirect_pc"}, redirect_pc, e.rpc);
  endtask

  // Advance one cycle, then compare the output register against the scoreboard.
  task automatic step();
    logic held;
    exp_t e;
    held = model_ov && !out_ready && !flush;
    @(posedge clk);
    #1;
    if (acc_pending) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'(1), 32'(0));
      end else begin
        e = sb_q.pop_front();
        check_outputs(e.tag, e, e.taken);
        last = e;
      end
      model_ov = 1'b1;
    end else if (held) begin
      check_outputs({last.tag, ".held"}, last, 1'b0);
    end else begin
      check("idle.valid",    32'(out_valid),      32'(1'b0));
      check("idle.redirect", 32'(redirect_valid), 32'(1'b0));
      model_ov = 1'b0;
    end
    acc_pending = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".valid"},    32'(out_valid),      32'(0));
    check({tag, ".redirect"}, 32'(redirect_valid), 32'(0));
    check({tag, ".pc"},       out_pc,              32'(0));
    check({tag, ".result"},   out_result,          32'(0));
    check({tag, ".store"},    out_store_data,      32'(0));
    check({tag, ".rd"},       32'(out_rd_addr),    32'(0));
    check({tag, ".rpc"},      redirect_pc,         32'(0));
  endtask

  initial begin
    vectors = 0; miscompares = 0; acc_pending = 1'b0; model_ov = 1'b0;
    rst_n = 1'b0; out_ready = 1'b1;
    instr(32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, ALU_ADD, 1'b0, 1'b0, 0);
    fwd_mem_rd = 5'd0; fwd_mem_value = 32'h0; fwd_wb_rd = 5'd0; fwd_wb_value = 32'h0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    check("reset.in_ready", 32'(in_ready), 32'(1));
    rst_n = 1'b1;

    // add x3, x1, x2
    instr(32'h10, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 32'h0, ALU_ADD, 1'b0, 1'b0, 0);
    expect_out("add", 32'd12, 32'd7, 5'd3, 1'b0, 32'h0);
    step();

    // addi with wrap; store data still follows rs2
    instr(32'h14, 5'd1, 32'hFFFF_FFFF, 5'd2, 32'h77, 5'd5, 32'h1, ALU_ADD, 1'b0, 1'b1, 0);
    expect_out("addi_wrap", 32'h0, 32'h77, 5'd5, 1'b0, 32'h0);
    step();

    // MEM beats WB; rs2 = x0 reads zero
    instr(32'h18, 5'd1, 32'h1111, 5'd0, 32'h55, 5'd6, 32'h0, ALU_ADD, 1'b0, 1'b0, 0);
    fwd_mem_valid = 1'b1; fwd_mem_rd = 5'd1; fwd_mem_value = 32'hAAAA;
    fwd_wb_valid  = 1'b1; fwd_wb_rd  = 5'd1; fwd_wb_value  = 32'hBBBB;
    expect_out("fwd_mem_wins", 32'hAAAA, 32'h0, 5'd6, 1'b0, 32'h0);
    step();

    // WB on rs1, MEM on rs2
    instr(32'h1C, 5'd1, 32'h1111, 5'd2, 32'h2222, 5'd7, 32'h0, ALU_ADD, 1'b0, 1'b0, 0);
    fwd_mem_valid = 1'b1; fwd_mem_rd = 5'd2; fwd_mem_value = 32'h1234;
    fwd_wb_valid  = 1'b1; fwd_wb_rd  = 5'd1; fwd_wb_value  = 32'hBBBB;
    expect_out("fwd_wb_rs1", 32'hCDEF, 32'h1234, 5'd7, 1'b0, 32'h0);
    step();

    // x0 never forwarded
    instr(32'h20, 5'd0, 32'h33, 5'd2, 32'd1, 5'd8, 32'h0, ALU_ADD, 1'b0, 1'b0, 0);
    fwd_mem_valid = 1'b1; fwd_mem_rd = 5'd0; fwd_mem_value = 32'd9;
    expect_out("fwd_x0", 32'd1, 32'd1, 5'd8, 1'b0, 32'h0);
    step();

    // sra and pc-relative operand
    instr(32'h24, 5'd1, 32'h8000_0000, 5'd2, 32'd4, 5'd9, 32'h0, ALU_SRA, 1'b0, 1'b0, 0);
    expect_out("sra", 32'hF800_0000, 32'd4, 5'd9, 1'b0, 32'h0);
    step();
    instr(32'h200, 5'd1, 32'h5, 5'd2, 32'h6, 5'd10, 32'h1000, ALU_ADD, 1'b1, 1'b1, 0);
    expect_out("auipc", 32'h1200, 32'h6, 5'd10, 1'b0, 32'h0);
    step();

    // taken beq; the instruction in the pulse cycle is dropped, then re-offered
    instr(32'h100, 5'd1, 32'h42, 5'd2, 32'h42, 5'd9, 32'h20, ALU_COMPARE_EQ, 1'b0, 1'b0, 1);
    expect_out("beq_taken", 32'd1, 32'h42, 5'd0, 1'b1, 32'h120);
    step();
    instr(32'h104, 5'd1, 32'd3, 5'd2, 32'd4, 5'd11, 32'h0, ALU_ADD, 1'b0, 1'b0, 0);
    step();
    expect_out("after_beq", 32'd7, 32'd4, 5'd11, 1'b0, 32'h0);
    step();

    // not-taken bne; following instruction flows back-to-back
    instr(32'h300, 5'd1, 32'h9, 5'd2, 32'h9, 5'd4, 32'h40, ALU_COMPARE_NE, 1'b0, 1'b0, 1);
    expect_out("bne_not_taken", 32'd0, 32'h9, 5'd0, 1'b0, 32'h0);
    step();
    instr(32'h304, 5'd1, 32'hF0, 5'd2, 32'h0F, 5'd12, 32'h0, ALU_OR, 1'b0, 1'b0, 0);
    expect_out("or_b2b", 32'hFF, 32'h0F, 5'd12, 1'b0, 32'h0);
    step();

    // jalr clears bit 0
    instr(32'h40, 5'd1, 32'h1001, 5'd2, 32'h5, 5'd1, 32'h2, ALU_ADD, 1'b0, 1'b1, 3);
    expect_out("jalr", 32'h44, 32'h5, 5'd1, 1'b1, 32'h1002);
    step();
    idle();
    step();

    // jal target wraps around the address space
    instr(32'hFFFF_FFF0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd1, 32'h20, ALU_ADD, 1'b1, 1'b1, 2);
    expect_out("jal_wrap", 32'hFFFF_FFF4, 32'h0, 5'd1, 1'b1, 32'h10);
    step();
    idle();
    step();

    // backpressure: taken jal stalled, redirect still one cycle, next loads on release
    out_ready = 1'b0;
    instr(32'h500, 5'd0, 32'h0, 5'd0, 32'h0, 5'd2, 32'h80, ALU_ADD, 1'b1, 1'b1, 2);
    expect_out("jal_stall", 32'h504, 32'h0, 5'd2, 1'b1, 32'h580);
    step();
    instr(32'h580, 5'd1, 32'd20, 5'd2, 32'd30, 5'd13, 32'h0, ALU_ADD, 1'b0, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall.in_ready", 32'(in_ready), 32'(0));
    end
    out_ready = 1'b1;
    expect_out("after_stall", 32'd50, 32'd30, 5'd13, 1'b0, 32'h0);
    step();
    idle();
    step();

    // flush while held, then flush during accept
    out_ready = 1'b0;
    instr(32'h600, 5'd1, 32'd1, 5'd2, 32'd2, 5'd14, 32'h0, ALU_XOR, 1'b0, 1'b0, 0);
    expect_out("pre_flush", 32'd3, 32'd2, 5'd14, 1'b0, 32'h0);
    step();
    idle();
    flush = 1'b1;
    step();
    out_ready = 1'b1;
    instr(32'h604, 5'd1, 32'd1, 5'd2, 32'd2, 5'd15, 32'h0, ALU_ADD, 1'b0, 1'b0, 0);
    flush = 1'b1;
    step();
    idle();
    step();

    // reset mid-stall clears outputs without a clock edge and drops the pending jal
    out_ready = 1'b0;
    instr(32'h700, 5'd1, 32'h77, 5'd2, 32'h88, 5'd16, 32'h0, ALU_ADD, 1'b0, 1'b0, 0);
    expect_out("pre_reset", 32'hFF, 32'h88, 5'd16, 1'b0, 32'h0);
    step();
    instr(32'h800, 5'd0, 32'h0, 5'd0, 32'h0, 5'd1, 32'h40, ALU_ADD, 1'b1, 1'b1, 2);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle();
    out_ready = 1'b1;
    model_ov = 1'b0;
    step();
    check("sb_empty", 32'(sb_q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
